// File: rtl/vga_pkg.sv
// Default 640x480@60 VGA timing constants and derived totals.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_BAR_W     = 80;

    function automatic int span_total(int vis, int fp, int sw, int bp);
        return vis + fp + sw + bp;
    endfunction

    localparam int DEF_H_TOTAL =
        span_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL =
        span_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator with registered sync/blank/color pins.
// Optional color bars are built only with VGA_TEST_PATTERN_EN defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int BAR_W     = DEF_BAR_W
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] in_R,
    input  logic [7:0] in_G,
    input  logic [7:0] in_B,
    input  logic       test_mode,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       hs_c;
    logic       vs_c;
    logic       vis_c;
    logic [7:0] r_c;
    logic [7:0] g_c;
    logic [7:0] b_c;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign hs_c   = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_c   = ~((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign vis_c  = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    assign DrawX       = h_cnt;
    assign DrawY       = v_cnt;
    assign VGA_CLK     = pix_en;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = pix_en & h_last & v_last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

    logic [9:0] bar_sub;
    logic [2:0] bar;

    // Bar index tracks h_cnt / BAR_W, restarting with every line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bar_sub <= '0;
            bar     <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                bar_sub <= '0;
                bar     <= '0;
            end else if (bar_sub == BAR_LAST) begin
                bar_sub <= '0;
                bar     <= bar + 3'd1;
            end else begin
                bar_sub <= bar_sub + 10'd1;
            end
        end
    end

    always_comb begin
        r_c = in_R;
        g_c = in_G;
        b_c = in_B;
        if (test_mode) begin
            r_c = {8{bar[2]}};
            g_c = {8{bar[1]}};
            b_c = {8{bar[0]}};
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{test_mode, 10'(BAR_W)};
    assign r_c = in_R;
    assign g_c = in_G;
    assign b_c = in_B;
`endif

    // Sync, blank and color all share one pixel of pin latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= hs_c;
            VGA_VS      <= vs_c;
            VGA_BLANK_N <= vis_c;
            VGA_R       <= vis_c ? r_c : 8'h00;
            VGA_G       <= vis_c ? g_c : 8'h00;
            VGA_B       <= vis_c ? b_c : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a pixel-index reference model.
// A shrunken-timing instance runs whole frames; a default instance checks lines.
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int BW = 2;

    localparam int FHV = 640, FHF = 16, FHS = 96, FHB = 48;
    localparam int FHT = 800, FVT = 525, FVV = 480;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_r, in_g, in_b;
    logic       tm;

    logic [9:0] dx, dy;
    logic       vclk, hs, vs, bl, syn, fs;
    logic [7:0] vr, vg, vb;

    logic [9:0] f_dx, f_dy;
    logic       f_vclk, f_hs, f_vs, f_bl, f_syn, f_fs;
    logic [7:0] f_r, f_g, f_b;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BAR_W(BW)
    ) dut (
        .Clk(clk), .Reset_n(rst_n),
        .in_R(in_r), .in_G(in_g), .in_B(in_b), .test_mode(tm),
        .DrawX(dx), .DrawY(dy), .VGA_CLK(vclk),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bl), .VGA_SYNC_N(syn),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .frame_start(fs)
    );

    vga_timing_gen dut_full (
        .Clk(clk), .Reset_n(rst_n),
        .in_R(in_r), .in_G(in_g), .in_B(in_b), .test_mode(tm),
        .DrawX(f_dx), .DrawY(f_dy), .VGA_CLK(f_vclk),
        .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_bl), .VGA_SYNC_N(f_syn),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .frame_start(f_fs)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic sync_n(int c, int vis, int fp, int sw);
        return !(c >= vis + fp && c < vis + fp + sw);
    endfunction

    function automatic logic [23:0] color(int x, logic t, logic [23:0] rgb,
                                          int bw);
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] b;
        if (t) begin
            b = 3'((x / bw) % 8);
            return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        end
`endif
        return rgb;
    endfunction

    // Reference state: phase of the pixel enable and pixel index since reset.
    int          ph, p, x, y, xf, yf;
    logic        e_hs, e_vs, e_bl;
    logic [23:0] e_rgb;
    logic        ef_hs, ef_bl;
    logic [23:0] ef_rgb;
    logic        pe;
    logic        full_en = 1'b1;
    int          hs_lo = 0, bl_hi = 0;

    always @(posedge clk or negedge rst_n) begin
        pe = 1'b0;
        if (!rst_n) begin
            ph = 0; p = 0;
            e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = '0;
            ef_hs = 1; ef_bl = 0; ef_rgb = '0;
        end else begin
            if (ph == 1) begin
                x = p % HT; y = (p / HT) % VT;
                e_hs  = sync_n(x, HV, HF, HS);
                e_vs  = sync_n(y, VV, VF, VS);
                e_bl  = (x < HV) && (y < VV);
                e_rgb = e_bl ? color(x, tm, {in_r, in_g, in_b}, BW) : 24'h0;
                xf = p % FHT; yf = (p / FHT) % FVT;
                ef_hs  = sync_n(xf, FHV, FHF, FHS);
                ef_bl  = (xf < FHV) && (yf < FVV);
                ef_rgb = ef_bl ? color(xf, tm, {in_r, in_g, in_b}, 80) : 24'h0;
                p++;
                pe = 1'b1;
            end
            ph = 1 - ph;
        end
        #1;
        x = p % HT; y = (p / HT) % VT;
        check("vga_clk", vclk, ph[0]);
        check("drawx", dx, x);
        check("drawy", dy, y);
        check("hs", hs, e_hs);
        check("vs", vs, e_vs);
        check("blank_n", bl, e_bl);
        check("rgb", {vr, vg, vb}, e_rgb);
        check("sync_n", syn, 0);
        check("frame_start", fs, (ph == 1 && x == HT - 1 && y == VT - 1));
        if (full_en) begin
            check("f_drawx", f_dx, p % FHT);
            check("f_drawy", f_dy, (p / FHT) % FVT);
            check("f_hs", f_hs, ef_hs);
            check("f_vs", f_vs, 1);
            check("f_blank_n", f_bl, ef_bl);
            check("f_rgb", {f_r, f_g, f_b}, ef_rgb);
            check("f_frame_start", f_fs, 0);
            if (pe) begin
                if (!f_hs) hs_lo++;
                if (f_bl) bl_hi++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        in_r = 8'($urandom);
        in_g = 8'($urandom);
        in_b = 8'($urandom);
        tm   = 1'($urandom);
        if ($urandom_range(0, 3) == 0) in_r = 8'hAA;
    end

    initial begin
        rst_n = 1'b0;
        in_r = '0; in_g = '0; in_b = '0; tm = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        // 1700 pixels: two full lines plus 100 visible pixels of line 2.
        repeat (3400) @(posedge clk);
        #3;
        full_en = 1'b0;
        check("f_hs_low_pixels", hs_lo, 2 * FHS);
        check("f_blank_hi_pixels", bl_hi, 2 * FHV + 100);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(300, 2500)) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (2000) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
